// File: rtl/multicycle_ctrl_if.sv
`timescale 1ns/1ps
// Control/status bundle between the multi-cycle controller (master) and the
// yChip datapath plus shared memory (slave).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             INT;
  logic [5:0]       opcode;
  logic [5:0]       fncode;
  logic             zero;
  logic             mem_ready;
  logic [2:0]       state;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             reg_write;
  logic             reg_dst;
  logic             mem2reg;
  logic             alu_src;
  logic [2:0]       alu_op;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  INT, opcode, fncode, zero, mem_ready,
    output state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel,
           reg_write, reg_dst, mem2reg, alu_src, alu_op, illegal, bus_err, retired
  );

  modport slave (
    output INT, opcode, fncode, zero, mem_ready,
    input  state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel,
           reg_write, reg_dst, mem2reg, alu_src, alu_op, illegal, bus_err, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with Mealy
// strobes, stretches memory states on mem_ready, vectors on INT, halts on faults.
module multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);
  localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  // R-type function decode, returns {legal, alu_op}.
  function automatic logic [3:0] r_alu_dec(input logic [5:0] fn);
    case (fn)
      6'h24:   r_alu_dec = {1'b1, 3'd0};
      6'h25:   r_alu_dec = {1'b1, 3'd1};
      6'h20:   r_alu_dec = {1'b1, 3'd2};
      6'h22:   r_alu_dec = {1'b1, 3'd6};
      6'h2a:   r_alu_dec = {1'b1, 3'd7};
      default: r_alu_dec = {1'b0, 3'd0};
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               int_pend_q, int_pend_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic               mem_req_s, mem_we_s, addr_sel_s, ir_write_s, pc_write_s;
  logic [1:0]         pc_sel_s;
  logic               reg_write_s, reg_dst_s, mem2reg_s, alu_src_s;
  logic [2:0]         alu_op_s;
  logic               timeout_s;
  logic [3:0]         r_dec_s;

  // State register and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      int_pend_q <= 1'b1;
      wait_cnt_q <= {WCNT_W{1'b0}};
      retired_q  <= {CNT_W{1'b0}};
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state and Mealy strobe decode.
  always_comb begin
    state_d     = state_q;
    int_pend_d  = int_pend_q;
    wait_cnt_d  = wait_cnt_q;
    retired_d   = retired_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    addr_sel_s  = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_sel_s    = 2'd0;
    reg_write_s = 1'b0;
    reg_dst_s   = 1'b0;
    mem2reg_s   = 1'b0;
    alu_src_s   = 1'b0;
    alu_op_s    = 3'd0;
    timeout_s   = (wait_cnt_q == WAIT_LAST) && !bus.mem_ready;
    r_dec_s     = r_alu_dec(bus.fncode);

    // A request seen mid-instruction is remembered and served at the next FETCH.
    if (bus.INT && (state_q != S_FETCH)) begin
      int_pend_d = 1'b1;
    end else begin
      int_pend_d = int_pend_d;
    end

    case (state_q)
      S_FETCH: begin
        if (bus.INT || int_pend_q) begin
          pc_write_s = 1'b1;
          pc_sel_s   = 2'd3;
          int_pend_d = 1'b0;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else if (bus.mem_ready) begin
          mem_req_s  = 1'b1;
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_s) begin
          bus_err_d  = 1'b1;
          state_d    = S_HALT;
        end else begin
          mem_req_s  = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_J: begin
            pc_write_s = 1'b1;
            pc_sel_s   = 2'd2;
            retired_d  = retired_q + CNT_W'(1);
            state_d    = S_FETCH;
          end
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_d = S_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        case (bus.opcode)
          OP_R: begin
            if (r_dec_s[3]) begin
              alu_op_s = r_dec_s[2:0];
              state_d  = S_WB;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          end
          OP_LW, OP_SW: begin
            alu_src_s = 1'b1;
            alu_op_s  = 3'd2;
            state_d   = S_MEM;
          end
          OP_ADDI: begin
            alu_src_s = 1'b1;
            alu_op_s  = 3'd2;
            state_d   = S_WB;
          end
          OP_BEQ: begin
            alu_op_s   = 3'd6;
            pc_write_s = bus.zero;
            pc_sel_s   = 2'd1;
            retired_d  = retired_q + CNT_W'(1);
            state_d    = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (timeout_s) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          mem_req_s  = 1'b1;
          addr_sel_s = 1'b1;
          mem_we_s   = (bus.opcode == OP_SW);
          alu_src_s  = 1'b1;
          alu_op_s   = 3'd2;
          if (!bus.mem_ready) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end else if (bus.opcode == OP_SW) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = (bus.opcode == OP_R);
        mem2reg_s   = (bus.opcode == OP_LW);
        retired_d   = retired_q + CNT_W'(1);
        state_d     = S_FETCH;
      end
      S_HALT: begin
        // Leaving HALT is itself the vector cycle, so nothing stays pending.
        if (bus.INT) begin
          pc_write_s = 1'b1;
          pc_sel_s   = 2'd3;
          int_pend_d = 1'b0;
          state_d    = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = {WCNT_W{1'b0}};
    end else begin
      wait_cnt_d = wait_cnt_d;
    end
  end

  // Strobes are forced low while reset is asserted, so a mid-access reset cuts them at once.
  assign bus.state     = state_q;
  assign bus.mem_req   = rst_n & mem_req_s;
  assign bus.mem_we    = rst_n & mem_we_s;
  assign bus.addr_sel  = rst_n & addr_sel_s;
  assign bus.ir_write  = rst_n & ir_write_s;
  assign bus.pc_write  = rst_n & pc_write_s;
  assign bus.pc_sel    = rst_n ? pc_sel_s : 2'd0;
  assign bus.reg_write = rst_n & reg_write_s;
  assign bus.reg_dst   = rst_n & reg_dst_s;
  assign bus.mem2reg   = rst_n & mem2reg_s;
  assign bus.alu_src   = rst_n & alu_src_s;
  assign bus.alu_op    = rst_n ? alu_op_s : 3'd0;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.retired   = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Directed bench for multicycle_ctrl: per-cycle control word, sticky flags and
// retired count against hand-computed tables (WAIT_MAX=4 instance).
module tb_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl #(.CNT_W(16), .WAIT_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] F = 3'd0, D = 3'd1, X = 3'd2, M = 3'd3, W = 3'd4, H = 3'd7;
  // Control word: {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write, reg_dst, mem2reg, alu_src, alu_op}
  localparam logic [16:0] MREQ = 17'h02000, MWE = 17'h01000, ASEL = 17'h00800, IRW  = 17'h00400;
  localparam logic [16:0] PCW  = 17'h00200, RW  = 17'h00040, RD   = 17'h00020, M2R  = 17'h00010;
  localparam logic [16:0] ASRC = 17'h00008;

  typedef struct packed {
    logic [14:0] stim;
    logic [16:0] ctl;
    logic [1:0]  flg;
    logic [15:0] ret;
  } vec_t;

  function automatic logic [16:0] st_w(input logic [2:0] s);
    return {s, 14'd0};
  endfunction
  function automatic logic [16:0] pcs_w(input logic [1:0] p);
    return {8'd0, p, 7'd0};
  endfunction
  function automatic logic [16:0] aop_w(input logic [2:0] a);
    return {14'd0, a};
  endfunction
  function automatic logic [14:0] s(input logic i, input logic r, input logic z,
                                    input logic [5:0] op, input logic [5:0] fn);
    return {i, r, z, op, fn};
  endfunction
  function automatic logic [16:0] obs();
    return {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write,
            bus.pc_sel, bus.reg_write, bus.reg_dst, bus.mem2reg, bus.alu_src, bus.alu_op};
  endfunction

  task automatic drive(input logic [14:0] st);
    @(negedge clk);
    bus.INT       = st[14];
    bus.mem_ready = st[13];
    bus.zero      = st[12];
    bus.opcode    = st[11:6];
    bus.fncode    = st[5:0];
    #1;
  endtask

  logic [16:0] fok;
  logic [16:0] vec;
  logic [16:0] ms;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.INT = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.opcode = 6'h23; bus.fncode = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== 35'd0) begin
      errors++;
      $display("FAIL reset_idle: got ctl=%h flg=%b ret=%0d, expected all zero",
               obs(), {bus.illegal, bus.bus_err}, bus.retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.INT = 1'b0;
    #1;
    checks++;
    if (obs() !== vec) begin
      errors++;
      $display("FAIL reset_vector: got ctl=%h, expected ctl=%h", obs(), vec);
    end
  endtask

  task automatic test_lw();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h23, 6'h00), fok, 2'b00, 16'd0});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h23, 6'h00), st_w(D), 2'b00, 16'd0});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h23, 6'h00), st_w(X) | ASRC | aop_w(3'd2), 2'b00, 16'd0});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h23, 6'h00), st_w(M) | MREQ | ASEL | ASRC | aop_w(3'd2), 2'b00, 16'd0});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h23, 6'h00), st_w(W) | RW | M2R, 2'b00, 16'd0});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL lw[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_rtype();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h22), fok, 2'b00, 16'd1});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h22), st_w(D), 2'b00, 16'd1});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h22), st_w(X) | aop_w(3'd6), 2'b00, 16'd1});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h22), st_w(W) | RW | RD, 2'b00, 16'd1});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL rtype[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_branch_jump();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b1, 6'h04, 6'h00), fok, 2'b00, 16'd2});
    tv.push_back('{s(1'b0, 1'b1, 1'b1, 6'h04, 6'h00), st_w(D), 2'b00, 16'd2});
    tv.push_back('{s(1'b0, 1'b1, 1'b1, 6'h04, 6'h00), st_w(X) | PCW | pcs_w(2'd1) | aop_w(3'd6), 2'b00, 16'd2});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h04, 6'h00), fok, 2'b00, 16'd3});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h04, 6'h00), st_w(D), 2'b00, 16'd3});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h04, 6'h00), st_w(X) | pcs_w(2'd1) | aop_w(3'd6), 2'b00, 16'd3});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h02, 6'h00), fok, 2'b00, 16'd4});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h02, 6'h00), st_w(D) | PCW | pcs_w(2'd2), 2'b00, 16'd4});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL branch_jump[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_stall();
    vec_t tv[$];
    for (int k = 0; k < 3; k++) begin
      tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h08, 6'h00), st_w(F) | MREQ, 2'b00, 16'd5});
    end
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h08, 6'h00), fok, 2'b00, 16'd5});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h08, 6'h00), st_w(D), 2'b00, 16'd5});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h08, 6'h00), st_w(X) | ASRC | aop_w(3'd2), 2'b00, 16'd5});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h08, 6'h00), st_w(W) | RW, 2'b00, 16'd5});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL stall[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t tv[$];
    for (int k = 0; k < 3; k++) begin
      tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h08, 6'h00), st_w(F) | MREQ, 2'b00, 16'd6});
    end
    tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h08, 6'h00), st_w(F), 2'b00, 16'd6});
    tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h08, 6'h00), st_w(H), 2'b01, 16'd6});
    tv.push_back('{s(1'b1, 1'b0, 1'b0, 6'h08, 6'h00), st_w(H) | PCW | pcs_w(2'd3), 2'b01, 16'd6});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL timeout[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00), fok, 2'b01, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00), st_w(D), 2'b01, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00), st_w(H), 2'b11, 16'd6});
    tv.push_back('{s(1'b1, 1'b1, 1'b0, 6'h3f, 6'h00), st_w(H) | PCW | pcs_w(2'd3), 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h00), fok, 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h00), st_w(D), 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h00), st_w(X), 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h00, 6'h00), st_w(H), 2'b11, 16'd6});
    tv.push_back('{s(1'b1, 1'b1, 1'b0, 6'h00, 6'h00), st_w(H) | PCW | pcs_w(2'd3), 2'b11, 16'd6});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL illegal[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_int_sw();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), fok, 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), st_w(D), 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), st_w(X) | ASRC | aop_w(3'd2), 2'b11, 16'd6});
    tv.push_back('{s(1'b1, 1'b0, 1'b0, 6'h2b, 6'h00), ms, 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h2b, 6'h00), ms, 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), ms, 2'b11, 16'd6});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), vec, 2'b11, 16'd7});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), fok, 2'b11, 16'd7});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL int_sw[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t tv[$];
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), st_w(D), 2'b11, 16'd7});
    tv.push_back('{s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00), st_w(X) | ASRC | aop_w(3'd2), 2'b11, 16'd7});
    tv.push_back('{s(1'b0, 1'b0, 1'b0, 6'h2b, 6'h00), ms, 2'b11, 16'd7});
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].stim);
      checks++;
      if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== {tv[i].ctl, tv[i].flg, tv[i].ret}) begin
        errors++;
        $display("FAIL async_pre[%0d]: got ctl=%h flg=%b ret=%0d, expected ctl=%h flg=%b ret=%0d", i,
                 obs(), {bus.illegal, bus.bus_err}, bus.retired, tv[i].ctl, tv[i].flg, tv[i].ret);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(), bus.illegal, bus.bus_err, bus.retired} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: got ctl=%h flg=%b ret=%0d, expected all zero",
               obs(), {bus.illegal, bus.bus_err}, bus.retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.INT = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs() !== vec) begin
      errors++;
      $display("FAIL async_release_vector: got ctl=%h, expected ctl=%h", obs(), vec);
    end
    for (int i = 0; i < 2; i++) begin
      drive(s(1'b1, 1'b1, 1'b0, 6'h2b, 6'h00));
      checks++;
      if (obs() !== vec) begin
        errors++;
        $display("FAIL int_held[%0d]: got ctl=%h, expected ctl=%h", i, obs(), vec);
      end
    end
    drive(s(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00));
    checks++;
    if (obs() !== fok) begin
      errors++;
      $display("FAIL int_released: got ctl=%h, expected ctl=%h", obs(), fok);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fok = st_w(F) | MREQ | IRW | PCW;
    vec = st_w(F) | PCW | pcs_w(2'd3);
    ms  = st_w(M) | MREQ | MWE | ASEL | ASRC | aop_w(3'd2);
    test_reset();
    test_lw();
    test_rtype();
    test_branch_jump();
    test_stall();
    test_timeout();
    test_illegal();
    test_int_sw();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end
endmodule
